// File: rtl/exec_if.sv
// Execute-stage bus: decoded instruction and forwarded operands in, EX/WB register contents out.
// Flag outputs exist only when EXEC_FLAGS_EN is defined.
interface exec_if;
    logic       stall;
    logic       in_valid;
    logic [7:0] instr;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] prev_instr;
    logic [7:0] up_dat;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic       jmp_taken;
    logic [7:0] jmp_target;
`ifdef EXEC_FLAGS_EN
    logic       flag_z;
    logic       flag_c;
`endif

    modport master (
        output stall, in_valid, instr, in0, in1,
        input  prev_instr, up_dat, wb_en, wb_addr, jmp_taken, jmp_target
`ifdef EXEC_FLAGS_EN
        , input flag_z, flag_c
`endif
    );

    modport slave (
        input  stall, in_valid, instr, in0, in1,
        output prev_instr, up_dat, wb_en, wb_addr, jmp_taken, jmp_target
`ifdef EXEC_FLAGS_EN
        , output flag_z, flag_c
`endif
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: ALU into the EX/WB register, jump resolution and wrong-path squash.
// Optional zero/carry flags are built when EXEC_FLAGS_EN is defined.
module exec_stage #(
    parameter logic [7:0] BUBBLE_INSTR = 8'hC0
) (
    input  logic clk,
    input  logic rst_n,
    exec_if.slave bus
);
    typedef enum logic {RUN, KILL} state_e;

    state_e     state_q;
    logic [7:0] prev_q, up_q, tgt_q;
    logic       wb_q, jt_q;
    logic [1:0] op;
    logic [7:0] imm_sx;
    logic [7:0] alu_res;
`ifdef EXEC_FLAGS_EN
    logic       alu_c;
    logic       z_q, c_q;
`endif

    assign op     = bus.instr[7:6];
    assign imm_sx = {{5{bus.instr[2]}}, bus.instr[2:0]};

    // For shifts the carry is whatever bit falls off the end; an extra 0 bit
    // on the outgoing side makes a zero-amount shift report carry 0.
    always_comb begin
        alu_res = bus.in1;
`ifdef EXEC_FLAGS_EN
        alu_c   = 1'b0;
`endif
        case (op)
            2'b00: begin
`ifdef EXEC_FLAGS_EN
                {alu_c, alu_res} = {1'b0, bus.in1} + {1'b0, bus.in0};
`else
                alu_res = bus.in1 + bus.in0;
`endif
            end
            2'b01: begin
`ifdef EXEC_FLAGS_EN
                {alu_c, alu_res} = {1'b0, bus.in1} + {1'b0, imm_sx};
`else
                alu_res = bus.in1 + imm_sx;
`endif
            end
            2'b10: begin
                if (bus.instr[2]) begin
`ifdef EXEC_FLAGS_EN
                    {alu_res, alu_c} = {bus.in1, 1'b0} >> bus.instr[1:0];
`else
                    alu_res = bus.in1 >> bus.instr[1:0];
`endif
                end else begin
`ifdef EXEC_FLAGS_EN
                    {alu_c, alu_res} = {1'b0, bus.in1} << bus.instr[1:0];
`else
                    alu_res = bus.in1 << bus.instr[1:0];
`endif
                end
            end
            default: alu_res = bus.in1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            prev_q  <= BUBBLE_INSTR;
            up_q    <= 8'h00;
            wb_q    <= 1'b0;
            jt_q    <= 1'b0;
            tgt_q   <= 8'h00;
`ifdef EXEC_FLAGS_EN
            z_q     <= 1'b0;
            c_q     <= 1'b0;
`endif
        end else if (bus.stall) begin
            // Everything freezes except the jump pulse, which must not stretch.
            jt_q <= 1'b0;
        end else begin
            jt_q   <= 1'b0;
            wb_q   <= 1'b0;
            prev_q <= BUBBLE_INSTR;
            if (bus.in_valid) begin
                if (state_q == KILL) begin
                    state_q <= RUN;
                end else if (op == 2'b11) begin
                    prev_q  <= bus.instr;
                    jt_q    <= 1'b1;
                    tgt_q   <= {2'b00, bus.instr[5:0]};
                    state_q <= KILL;
                end else begin
                    prev_q <= bus.instr;
                    up_q   <= alu_res;
                    wb_q   <= 1'b1;
`ifdef EXEC_FLAGS_EN
                    z_q    <= (alu_res == 8'h00);
                    c_q    <= alu_c;
`endif
                end
            end
        end
    end

    assign bus.prev_instr = prev_q;
    assign bus.up_dat     = up_q;
    assign bus.wb_en      = wb_q;
    assign bus.wb_addr    = prev_q[5:3];
    assign bus.jmp_taken  = jt_q;
    assign bus.jmp_target = tgt_q;
`ifdef EXEC_FLAGS_EN
    assign bus.flag_z     = z_q;
    assign bus.flag_c     = c_q;
`endif
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 4-stage 8-bit pipeline. It sits directly downstream of the operand forwarding mux.
- It consumes the decoded instruction plus the two forwarded operands, computes the ALU result and registers it into the EX/WB pipeline register.
- Its registered outputs drive register-file writeback and loop back to the forwarding mux as the previous instruction and its result.
- It resolves jumps and squashes the wrong-path instruction that follows a taken jump.

Parameters:
- BUBBLE_INSTR, 8'hC0, encoding placed in prev_instr for a squashed or empty slot. Opcode must be 2'b11 so the forwarding mux never forwards it.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold all stage state; no instruction is accepted
- in_valid  input  1  instr/in0/in1 carry a real instruction this cycle
- instr  input  8  instruction word [7:6] op, [5:3] rd, [2:0] rs/imm
- in0  input  8  forwarded rs operand
- in1  input  8  forwarded rd operand
- prev_instr  output  8  registered instruction (BUBBLE_INSTR when no valid result)
- up_dat  output  8  registered ALU result
- wb_en  output  1  write up_dat to register prev_instr[5:3]
- wb_addr  output  3  equal to prev_instr[5:3]
- jmp_taken  output  1  one-cycle pulse, redirect fetch
- jmp_target  output  8  {2'b00, jumped instr[5:0]}, valid while jmp_taken=1

Behaviour:
- Reset (async, rst_n=0): prev_instr=BUBBLE_INSTR, up_dat=0, wb_en=0, jmp_taken=0, jmp_target=0, state=RUN. Outputs take reset values immediately, not at the next edge.
- ALU result is registered with 1-cycle latency. An instruction accepted at edge N is visible on the outputs after edge N.
- Op 00 ADD: result = in1 + in0, mod 256.
- Op 01 ADDI: result = in1 + sign-extend(instr[2:0]). The immediate range is -4..+3, mod 256.
- Op 10 SHF: instr[2]=0 gives in1 << instr[1:0]; instr[2]=1 gives in1 >> instr[1:0] (logical). Vacated bits are 0.
- Op 11 JMP: no writeback; prev_instr captures the JMP word itself (opcode 11, so never forwarded); up_dat holds its old value; jmp_taken=1 for exactly one cycle; jmp_target = {2'b00, instr[5:0]}.
- wb_en=1 only for an accepted valid op 00/01/10. Otherwise wb_en=0, and prev_instr=BUBBLE_INSTR except in the JMP case.
- FSM states:
  - RUN: accepts instructions normally.
  - KILL: entered on the edge that accepts a JMP. The next accepted in_valid instruction is the wrong-path one: it is squashed (prev_instr=BUBBLE_INSTR, wb_en=0, no jmp_taken) and the FSM returns to RUN.
  - In KILL, cycles with in_valid=0 do not consume the kill; the FSM stays in KILL.
- Stall=1:
  - Every register holds, including state, prev_instr, up_dat and wb_en.
  - jmp_taken is forced to 0 on the next edge, so the pulse is never stretched. jmp_target holds.
- in_valid=0 with stall=0: inserts a bubble (prev_instr=BUBBLE_INSTR, wb_en=0, up_dat holds).
- JMP while in KILL: treated as the squashed instruction. It is ignored and produces no pulse.
- stall and rst_n both active: reset wins.

Optional Feature:
- Macro: EXEC_FLAGS_EN.
- When defined:
  - Adds outputs flag_z (1) and flag_c (1).
  - Registered alongside up_dat for accepted ops 00/01/10.
  - z = (result==0).
  - c = carry-out of the 9-bit sum for ADD/ADDI. For SHF, c = last bit shifted out, or 0 when the shift amount is 0.
  - Both reset to 0, hold on stall, bubble, JMP and squash.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset release, then ADD instr=8'h0A (rd=1, rs=2), in0=8'h05, in1=8'hFE, in_valid=1 -> next cycle up_dat=8'h03, wb_en=1, wb_addr=1, prev_instr=8'h0A; flags build: flag_c=1, flag_z=0.
- ADDI instr=8'h4C (rd=1, imm=3'b100), in1=8'h02 -> up_dat=8'hFE, wb_en=1. SHF instr=8'h87 (right, amt 3), in1=8'hF0 -> up_dat=8'h1E.
- JMP instr=8'hE5 followed by ADD 8'h0A -> cycle1: jmp_taken=1, jmp_target=8'h25, wb_en=0, prev_instr=8'hE5; cycle2: jmp_taken=0, ADD squashed (prev_instr=8'hC0, wb_en=0); third instr executes normally.
- JMP, then two in_valid=0 cycles, then ADD -> ADD still squashed, and the following ADD is written back.
- Accept ADD (result 8'h03), then stall=1 for 3 cycles with a changing instr -> outputs frozen at 8'h03/wb_en=1. A JMP accepted just before a stall -> jmp_taken high for exactly 1 cycle.
- Assert rst_n=0 mid-cycle while wb_en=1 and state=KILL -> outputs go immediately to reset values; after release, the first ADD is not squashed.
